// File: rtl/router_pkg.sv
// Shared definitions for the router output arbiter: port count, header
// field layout, default stall timeout and the arbiter state encoding.
package router_pkg;

    localparam int NUM_PORTS   = 3;
    localparam int LEN_MSB     = 7;
    localparam int LEN_LSB     = 2;
    localparam int ADDR_W      = 2;
    localparam int LEN_W       = LEN_MSB - LEN_LSB + 1;
    localparam int TIMEOUT_DEF = 30;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        PAYLOAD = 2'd2,
        PARITY  = 2'd3
    } arb_state_e;

    // Port index after p, wrapping 2 back to 0.
    function automatic logic [ADDR_W-1:0] next_port(input logic [ADDR_W-1:0] p);
        return (p == ADDR_W'(NUM_PORTS - 1)) ? '0 : p + 1'b1;
    endfunction

endpackage

// File: rtl/router_rr_pick.sv
// Combinational round-robin picker: first requesting port scanning
// rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3).
module router_rr_pick
    import router_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req,
    input  logic [ADDR_W-1:0]    rr_ptr,
    output logic [ADDR_W-1:0]    pick,
    output logic                 any_req
);

    logic [ADDR_W-1:0] cand;

    always_comb begin
        pick    = '0;
        any_req = 1'b0;
        cand    = rr_ptr;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!any_req && req[cand]) begin
                pick    = cand;
                any_req = 1'b1;
            end
            cand = next_port(cand);
        end
    end

endmodule

// File: rtl/router_out_arb.sv
// Packet-atomic round-robin arbiter draining three show-ahead router FIFOs
// onto one valid/ready byte link, with parity check and stall timeout.
module router_out_arb
    import router_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int TO_W    = 5
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic [NUM_PORTS-1:0] fifo_empty,
    input  logic [DATA_W-1:0]    data_out_0,
    input  logic [DATA_W-1:0]    data_out_1,
    input  logic [DATA_W-1:0]    data_out_2,
    output logic [NUM_PORTS-1:0] read_enb,
    output logic [NUM_PORTS-1:0] soft_reset,
    output logic [DATA_W-1:0]    out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_sop,
    output logic                 out_eop,
    output logic [ADDR_W-1:0]    grant,
    output logic                 grant_valid,
    output logic                 parity_err,
    output logic                 pkt_done
);

    arb_state_e           state_q, state_d;
    logic [ADDR_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [ADDR_W-1:0]    grant_q, grant_d;
    logic                 grant_valid_q, grant_valid_d;
    logic [LEN_W-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0]    par_q, par_d;
    logic [TO_W-1:0]      stall_q, stall_d;
    logic                 pkt_done_q, pkt_done_d;
    logic                 parity_err_q, parity_err_d;
    logic [NUM_PORTS-1:0] soft_reset_q, soft_reset_d;

    logic [NUM_PORTS-1:0] req;
    logic [ADDR_W-1:0]    pick;
    logic                 any_req;
    logic                 active;
    logic                 head_valid;
    logic                 hs;
    logic [DATA_W-1:0]    head_data;

    // A FIFO being flushed this cycle is not offered for a new grant.
    assign req = ~fifo_empty & ~soft_reset_q;

    router_rr_pick u_pick (
        .req     (req),
        .rr_ptr  (rr_ptr_q),
        .pick    (pick),
        .any_req (any_req)
    );

    always_comb begin
        case (grant_q)
            2'd0:    head_data = data_out_0;
            2'd1:    head_data = data_out_1;
            default: head_data = data_out_2;
        endcase
    end

    assign active     = (state_q != IDLE);
    assign head_valid = active & ~fifo_empty[grant_q];
    assign hs         = head_valid & out_ready;

    assign out_valid   = head_valid;
    assign out_data    = active ? head_data : '0;
    assign out_sop     = (state_q == HEADER);
    assign out_eop     = (state_q == PARITY);
    assign grant       = grant_q;
    assign grant_valid = grant_valid_q;
    assign pkt_done    = pkt_done_q;
    assign parity_err  = parity_err_q;
    assign soft_reset  = soft_reset_q;

    always_comb begin
        read_enb = '0;
        if (hs) begin
            read_enb[grant_q] = 1'b1;
        end
    end

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        grant_d       = grant_q;
        grant_valid_d = grant_valid_q;
        cnt_d         = cnt_q;
        par_d         = par_q;
        stall_d       = stall_q;
        pkt_done_d    = 1'b0;
        parity_err_d  = 1'b0;
        soft_reset_d  = '0;

        if (state_q == IDLE) begin
            stall_d = '0;
            if (any_req) begin
                grant_d       = pick;
                grant_valid_d = 1'b1;
                state_d       = HEADER;
            end
        end else if (hs) begin
            stall_d = '0;
            case (state_q)
                HEADER: begin
                    cnt_d   = head_data[LEN_MSB:LEN_LSB];
                    par_d   = head_data;
                    state_d = (head_data[LEN_MSB:LEN_LSB] == '0) ? PARITY : PAYLOAD;
                end
                PAYLOAD: begin
                    par_d = par_q ^ head_data;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == LEN_W'(1)) begin
                        state_d = PARITY;
                    end
                end
                default: begin
                    pkt_done_d    = 1'b1;
                    parity_err_d  = (head_data != par_q);
                    rr_ptr_d      = next_port(grant_q);
                    grant_valid_d = 1'b0;
                    state_d       = IDLE;
                end
            endcase
        end else if (stall_q == TO_W'(TIMEOUT - 1)) begin
            // Link stuck too long: flush the owner and release the link.
            soft_reset_d[grant_q] = 1'b1;
            rr_ptr_d              = next_port(grant_q);
            grant_valid_d         = 1'b0;
            stall_d               = '0;
            state_d               = IDLE;
        end else begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            cnt_q         <= '0;
            par_q         <= '0;
            stall_q       <= '0;
            pkt_done_q    <= 1'b0;
            parity_err_q  <= 1'b0;
            soft_reset_q  <= '0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            grant_q       <= grant_d;
            grant_valid_q <= grant_valid_d;
            cnt_q         <= cnt_d;
            par_q         <= par_d;
            stall_q       <= stall_d;
            pkt_done_q    <= pkt_done_d;
            parity_err_q  <= parity_err_d;
            soft_reset_q  <= soft_reset_d;
        end
    end

endmodule
